// File: rtl/mdu_sequencer.sv
// mdu_sequencer: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO regs
// ports: clk, reset(n), start/op/A/B in; busy, stall, hi, lo out; MDU_CANCEL_EN adds cancel
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic               b_zero;

  logic               kill;
  logic               md_op;
  logic               sgn_op;
  logic               div_op;
  logic               accept;
  logic               commit;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    md_op  = 1'b0;
    sgn_op = 1'b0;
    div_op = 1'b0;
    unique case (1'b1)
      (op == OP_MULT): begin
        md_op  = 1'b1;
        sgn_op = 1'b1;
      end
      (op == OP_MULTU): begin
        md_op  = 1'b1;
      end
      (op == OP_DIV): begin
        md_op  = 1'b1;
        sgn_op = 1'b1;
        div_op = 1'b1;
      end
      (op == OP_DIVU): begin
        md_op  = 1'b1;
        div_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign abs_a  = (sgn_op && A[WIDTH-1]) ? -A : A;
  assign abs_b  = (sgn_op && B[WIDTH-1]) ? -B : B;
  assign accept = start && md_op && (state == IDLE) && !kill;
  assign commit = (state == FIX) && !kill;
  assign busy   = (state != IDLE);
  assign stall  = busy | (start & md_op);

  // acc layout: mult = {upper partial, multiplier shifting out};
  // div = {partial remainder, dividend shifting out / quotient in}
  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ok    = ~div_diff[WIDTH+1];
    div_rem   = div_ok ? div_diff[WIDTH:0] : div_shift;
    if (is_div)
      acc_step = {div_rem, acc[WIDTH-2:0], div_ok};
    else
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  // divide-by-zero leaves rem = |A|, so the dividend-sign fixup
  // restores the raw dividend in hi
  always_comb begin
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    prod = (neg_a ^ neg_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_a ? -rem : rem;
      res_lo = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        if (kill)
          state_n = IDLE;
        else if (cnt == CW'(ITER - 1))
          state_n = FIX;
      end
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        acc    <= {{(WIDTH+1){1'b0}}, abs_a};
        opb    <= abs_b;
        is_div <= div_op;
        neg_a  <= sgn_op & A[WIDTH-1];
        neg_b  <= sgn_op & B[WIDTH-1];
        b_zero <= (B == '0);
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= acc_step;
      end

      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if ((state == IDLE) && start && !kill) begin
        if (op == OP_MTHI) hi <= A;
        if (op == OP_MTLO) lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed + random checks of mdu_sequencer
// against an arithmetic HI/LO reference model
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int          cmp  = 0;
  int          errs = 0;
  logic [31:0] mhi  = '0;
  logic [31:0] mlo  = '0;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin
        p = 64'(sa * sb);
        {mhi, mlo} = p;
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = p;
      end
      3'd3: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFFFFFF;
          mhi = a;
        end else begin
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end
      end
      3'd4: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFFFFFF;
          mhi = a;
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      3'd5: mhi = a;
      3'd6: mlo = a;
      default: ;
    endcase
  endtask

  // drive mid-cycle, accept on next edge, then follow to completion
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] h0;
    logic [31:0] l0;
    logic        md;
    logic        held;
    int          n;
    md   = (o >= 3'd1) && (o <= 3'd4);
    h0   = mhi;
    l0   = mlo;
    op   = o;
    A    = a;
    B    = b;
    start = 1'b1;
    #1;
    chk("stall_req", 32'(stall), 32'(md));
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    A     = $urandom;
    B     = $urandom;
    model(o, a, b);
    if (!md) begin
      chk("busy_idle", 32'(busy), 32'd0);
    end else begin
      n    = 0;
      held = 1'b1;
      while (busy === 1'b1 && n < 60) begin
        n++;
        if (hi !== h0 || lo !== l0 || stall !== 1'b1) held = 1'b0;
        if (n == 5) begin
          start = 1'b1;
          op    = 3'd5;
          A     = 32'hDEADBEEF;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      chk("busy_cycles", 32'(n), 32'd33);
      chk("held_stall", 32'(held), 32'd1);
    end
    chk("hi", hi, mhi);
    chk("lo", lo, mlo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    issue(3'd1, 32'hFFFFFFFD, 32'h00000005);
    chk("mult_hi_k", hi, 32'hFFFFFFFF);
    chk("mult_lo_k", lo, 32'hFFFFFFF1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi_k", hi, 32'hFFFFFFFE);
    chk("multu_lo_k", lo, 32'h00000001);
    issue(3'd3, 32'hFFFFFFF9, 32'h00000002);
    chk("div_lo_k", lo, 32'hFFFFFFFD);
    chk("div_hi_k", hi, 32'hFFFFFFFF);
    issue(3'd4, 32'h7, 32'h0);
    chk("divu0_lo_k", lo, 32'hFFFFFFFF);
    chk("divu0_hi_k", hi, 32'h00000007);
    issue(3'd3, 32'hFFFFFFF9, 32'h0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo_k", lo, 32'h80000000);
    chk("ovf_hi_k", hi, 32'h00000000);
    issue(3'd6, 32'h12345678, 32'h0);
    chk("mtlo_k", lo, 32'h12345678);
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    issue(3'd0, 32'h11111111, 32'h2);
    issue(3'd7, 32'h22222222, 32'h3);

    op    = 3'd3;
    A     = 32'h80000000;
    B     = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    mhi = '0;
    mlo = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd4, 32'h100, 32'h7);
    chk("divu_lo_k", lo, 32'h00000024);
    chk("divu_hi_k", hi, 32'h00000004);

`ifdef MDU_CANCEL_EN
    op    = 3'd1;
    A     = 32'd3;
    B     = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_hi", hi, mhi);
    chk("cancel_lo", lo, mlo);
    issue(3'd1, 32'd3, 32'd4);
    chk("cancel_redo_lo", lo, 32'h0000000C);
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: ra = 32'h80000000;
        1: ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
